// File: rtl/spike_frame_ram_if.sv
// Host write port, run control and streaming output of the spike frame RAM.
interface spike_frame_ram_if #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = 16
);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_err;
  logic             start;
  logic [AW-1:0]    start_addr;
  logic [AW-1:0]    num_steps;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_step;

  modport master (
    output wr_en, wr_addr, wr_data, start, start_addr, num_steps, out_ready,
    input  wr_err, busy, done, out_valid, out_data, out_step
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, start_addr, num_steps, out_ready,
    output wr_err, busy, done, out_valid, out_data, out_step
  );
endinterface

// File: rtl/spike_frame_ram.sv
// Input spike frame memory: host-written frames streamed one per timestep over valid/ready.
module spike_frame_ram #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned DEPTH     = 1002,
  parameter int unsigned AW        = 16,
  parameter              INIT_FILE = "./testbench_files/input_spike_ram.txt"
) (
  input  logic         clk,
  input  logic         rst_n,
  spike_frame_ram_if.slave bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  if ((64'(1) << AW) < 64'(DEPTH)) begin : g_cfg_check
    $error("spike_frame_ram: AW too narrow for DEPTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_d;
  logic [AW-1:0]    rd_addr, steps, issued;
  logic             rd_en, accept, wr_ok;
  logic             busy_q, done_q, valid_q, wr_err_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    step_q;

  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < DEPTH);

  // Storage write port; not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[IW'(bus.wr_addr)] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and read issue; a read only issues when the output slot is free.
  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.num_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = !valid_q || bus.out_ready;
        if (rd_en && (issued == steps - AW'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q && bus.out_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address sequencer, output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      steps    <= '0;
      issued   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      step_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      if (accept) begin
        rd_addr <= AW'(32'(bus.start_addr) % DEPTH);
        steps   <= bus.num_steps;
        issued  <= '0;
      end
      if (rd_en) begin
        data_q  <= mem[IW'(rd_addr)];
        step_q  <= issued;
        valid_q <= 1'b1;
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
        issued  <= issued + AW'(1);
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_step  = step_q;
  assign bus.wr_err    = wr_err_q;

endmodule
